// File: rtl/hazard_scoreboard.sv
// D-stage stall/forward controller: shadow pipeline of (dest, Tnew) for STAGES stages after D,
// MDU busy countdown, per-source forward selects and synchronous flush.
module hazard_scoreboard #(
    parameter  int unsigned STAGES   = 2,
    parameter  int unsigned AW       = 5,
    parameter  int unsigned TW       = 2,
    parameter  int unsigned MULT_CYC = 5,
    parameter  int unsigned DIV_CYC  = 10,
    localparam int unsigned SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D_valid,
    input  logic [AW-1:0] D_a1,
    input  logic [AW-1:0] D_a2,
    input  logic [TW-1:0] D_tuse1,
    input  logic [TW-1:0] D_tuse2,
    input  logic [AW-1:0] D_a3,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_is_md,
    input  logic          D_md_start,
    input  logic          D_md_is_div,
    input  logic          flush,
    output logic          do_stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          mdu_busy
);

    localparam int unsigned MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic [AW-1:0] ent_a3   [1:STAGES];
    logic [TW-1:0] ent_tnew [1:STAGES];
    logic          md_pend;
    logic          md_div;
    logic [CW-1:0] busy_cnt;
    logic          stall_r;
    logic          stall_md;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Scan oldest to youngest so the youngest matching producer ends up selected.
    always_comb begin
        stall_r  = 1'b0;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int unsigned k = STAGES; k >= 1; k--) begin
            if (ent_a3[k] != '0) begin
                if (ent_a3[k] == D_a1) begin
                    fwd_sel1 = SW'(k);
                    if (D_tuse1 < ent_tnew[k]) stall_r = 1'b1;
                end
                if (ent_a3[k] == D_a2) begin
                    fwd_sel2 = SW'(k);
                    if (D_tuse2 < ent_tnew[k]) stall_r = 1'b1;
                end
            end
        end
        if (!D_valid) begin
            stall_r  = 1'b0;
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
    end

    always_comb begin
        stall_md = D_valid & D_is_md & (md_pend | (busy_cnt != '0));
        do_stall = stall_r | stall_md;
        mdu_busy = (busy_cnt != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= STAGES; k++) begin
                ent_a3[k]   <= '0;
                ent_tnew[k] <= '0;
            end
            md_pend  <= 1'b0;
            md_div   <= 1'b0;
            busy_cnt <= '0;
        end else begin
            if (flush) begin
                for (int unsigned k = 1; k <= STAGES; k++) begin
                    ent_a3[k]   <= '0;
                    ent_tnew[k] <= '0;
                end
                md_pend <= 1'b0;
            end else begin
                for (int unsigned k = 1; k < STAGES; k++) begin
                    ent_a3[k+1]   <= ent_a3[k];
                    ent_tnew[k+1] <= sat_dec(ent_tnew[k]);
                end
                if (do_stall || !D_valid) begin
                    ent_a3[1]   <= '0;
                    ent_tnew[1] <= '0;
                end else begin
                    ent_a3[1]   <= D_a3;
                    ent_tnew[1] <= D_tnew;
                end
                md_pend <= ~do_stall & D_valid & D_md_start;
                md_div  <= D_md_is_div;
            end
            // The MDU is never cancelled by flush: a pending start still loads the counter.
            if (md_pend)
                busy_cnt <= md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a STAGES=2 and a STAGES=3 instance share the stimulus;
// expected outputs are queued at drive time and popped at the falling edge.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       D_valid;
    logic [4:0] D_a1, D_a2, D_a3;
    logic [1:0] D_tuse1, D_tuse2, D_tnew;
    logic       D_is_md, D_md_start, D_md_is_div, flush;

    logic       do_stall, mdu_busy;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic       do_stall3, mdu_busy3;
    logic [1:0] fwd3_sel1, fwd3_sel2;

    always #5 clk = ~clk;

    hazard_scoreboard #(.STAGES(2), .AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_a1(D_a1), .D_a2(D_a2),
        .D_tuse1(D_tuse1), .D_tuse2(D_tuse2), .D_a3(D_a3), .D_tnew(D_tnew),
        .D_is_md(D_is_md), .D_md_start(D_md_start), .D_md_is_div(D_md_is_div),
        .flush(flush), .do_stall(do_stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mdu_busy(mdu_busy)
    );

    hazard_scoreboard #(.STAGES(3), .AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut3 (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_a1(D_a1), .D_a2(D_a2),
        .D_tuse1(D_tuse1), .D_tuse2(D_tuse2), .D_a3(D_a3), .D_tnew(D_tnew),
        .D_is_md(D_is_md), .D_md_start(D_md_start), .D_md_is_div(D_md_is_div),
        .flush(flush), .do_stall(do_stall3), .fwd_sel1(fwd3_sel1), .fwd_sel2(fwd3_sel2),
        .mdu_busy(mdu_busy3)
    );

    typedef struct {
        logic       on3;
        logic       valid;
        logic [4:0] a1, a2, a3;
        logic [1:0] tu1, tu2, tn;
        logic       md, st, dv, fl;
        logic       es, eb, chkf;
        logic [1:0] ef1, ef2;
        string      nm;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(int on3, int valid, int a1, int tu1, int a2, int tu2,
                                int a3, int tn, int md, int st, int dv, int fl,
                                int es, int ef1, int ef2, int eb, int chkf, string nm);
        vec_t v;
        v.on3 = 1'(on3);  v.valid = 1'(valid);
        v.a1 = 5'(a1);    v.tu1 = 2'(tu1);  v.a2 = 5'(a2);  v.tu2 = 2'(tu2);
        v.a3 = 5'(a3);    v.tn = 2'(tn);
        v.md = 1'(md);    v.st = 1'(st);    v.dv = 1'(dv);  v.fl = 1'(fl);
        v.es = 1'(es);    v.ef1 = 2'(ef1);  v.ef2 = 2'(ef2);
        v.eb = 1'(eb);    v.chkf = 1'(chkf); v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        D_valid = v.valid; D_a1 = v.a1; D_tuse1 = v.tu1; D_a2 = v.a2; D_tuse2 = v.tu2;
        D_a3 = v.a3; D_tnew = v.tn; D_is_md = v.md; D_md_start = v.st;
        D_md_is_div = v.dv; flush = v.fl;
    endtask

    task automatic sample();
        vec_t       e;
        logic       s, b;
        logic [1:0] f1, f2;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e  = exp_q.pop_front();
        s  = e.on3 ? do_stall3 : do_stall;
        b  = e.on3 ? mdu_busy3 : mdu_busy;
        f1 = e.on3 ? fwd3_sel1 : fwd_sel1;
        f2 = e.on3 ? fwd3_sel2 : fwd_sel2;
        chk({e.nm, ".stall"}, 32'(s), 32'(e.es));
        chk({e.nm, ".busy"},  32'(b), 32'(e.eb));
        if (e.chkf) begin
            chk({e.nm, ".fwd1"}, 32'(f1), 32'(e.ef1));
            chk({e.nm, ".fwd2"}, 32'(f2), 32'(e.ef2));
        end
    endtask

    task automatic step(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(mk(0, 1, 3, 0, 4, 0, 5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, "init"));
        #2;
        chk("reset.stall", 32'(do_stall), 0);
        chk("reset.busy",  32'(mdu_busy), 0);
        chk("reset.fwd1",  32'(fwd_sel1), 0);
        chk("reset.fwd2",  32'(fwd_sel2), 0);
        chk("reset3.stall", 32'(do_stall3), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // STAGES=2 single-cycle vectors
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t1_lw"));
        tbl.push_back(mk(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, "t1_stall"));
        tbl.push_back(mk(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, "t1_fwd"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t2_prod0"));
        tbl.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, "t2_cons"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t2_zero"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, "p6"));
        tbl.push_back(mk(0, 0, 6, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "bubble"));
        tbl.push_back(mk(0, 1, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 1, "c6_stall"));
        tbl.push_back(mk(0, 1, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "c6_gone"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "p8"));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "p9"));
        tbl.push_back(mk(0, 1, 8, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, "c89"));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // T3: mult then mflo, div then mflo
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "t3_mult"));
        for (int i = 0; i <= 6; i++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, (i < 6) ? 1 : 0, 0, 0,
                    (i >= 1 && i < 6) ? 1 : 0, 1, $sformatf("t3_mflo%0d", i)));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, "t3_div"));
        for (int i = 0; i <= 11; i++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, (i < 11) ? 1 : 0, 0, 0,
                    (i >= 1 && i < 11) ? 1 : 0, 1, $sformatf("t3_dmflo%0d", i)));

        // T4: flush kills the load-use stall but not the MDU countdown
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "t4_mult"));
        step(mk(0, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t4_lw"));
        step(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, "t4_flush"));
        step(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "t4_after"));
        for (int i = 0; i <= 3; i++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, (i < 3) ? 1 : 0, 0, 0,
                    (i < 3) ? 1 : 0, 1, $sformatf("t4_mflo%0d", i)));

        // T5: asynchronous reset in the middle of a divide
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, "t5_div"));
        for (int i = 0; i <= 4; i++)
            step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0,
                    (i >= 1) ? 1 : 0, 1, $sformatf("t5_mfhi%0d", i)));
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "t5_mfhi"));
        #2;
        chk("t5_pre.stall", 32'(do_stall), 1);
        chk("t5_pre.busy",  32'(mdu_busy), 1);
        reset = 1'b1;
        #1;
        chk("t5_rst.stall", 32'(do_stall), 0);
        chk("t5_rst.busy",  32'(mdu_busy), 0);
        chk("t5_rst3.busy", 32'(mdu_busy3), 0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "t5_after"));

        // T6: STAGES=3 instance, producer ageing out and saturating Tnew
        for (int i = 0; i < 3; i++)
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_idle"));
        step(mk(1, 1, 0, 0, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_p7"));
        for (int i = 1; i <= 3; i++)
            step(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 1,
                    $sformatf("t6_stall%0d", i)));
        step(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_dropped"));
        step(mk(1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_pa"));
        step(mk(1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t6_pb"));
        step(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "t6_young"));
        step(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, "t6_sat"));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
